// File: rtl/edge_evt_arb.sv
`default_nettype none
// ============================================================================
// Module      : edge_evt_arb
// Description : Multi-channel edge-event scheduler. Synchronises CH_NUM
//               asynchronous control lines, detects rising/falling edges per
//               channel under a per-channel mode, holds one pending event per
//               channel and shares a single valid/ready event port between
//               channels with round-robin arbitration.
// Optional    : `define EDGE_ARB_DEBOUNCE_EN adds a per-channel debounce
//               filter (DEB_CYC stable cycles) ahead of edge detection.
// Ports       : sys_clk      - system clock
//               sys_rst_n    - asynchronous active-low reset
//               ctrl_signal  - [CH_NUM] asynchronous control lines
//               edge_mode    - [2*CH_NUM] per channel 00 off/01 rise/10 fall/11 both
//               evt_valid    - event available
//               evt_ready    - consumer accepts event
//               evt_ch       - [IDX_W] channel index of presented event
//               evt_rise     - 1 rising edge, 0 falling edge
//               pend_mask    - [CH_NUM] registered pending flags
//               ovf_pulse    - [CH_NUM] one-cycle pulse when an event is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module edge_evt_arb #(
    parameter int CH_NUM  = 4,
    parameter int IDX_W   = 2,
    parameter int DEB_CYC = 15,
    parameter int DEB_W   = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [CH_NUM-1:0]     ctrl_signal,
    input  logic [2*CH_NUM-1:0]   edge_mode,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IDX_W-1:0]      evt_ch,
    output logic                  evt_rise,
    output logic [CH_NUM-1:0]     pend_mask,
    output logic [CH_NUM-1:0]     ovf_pulse
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    if (IDX_W != $clog2(CH_NUM) || DEB_CYC < 1 || DEB_CYC > (1 << DEB_W) - 1) begin : g_bad_cfg
        $error("edge_evt_arb: inconsistent CH_NUM/IDX_W/DEB_CYC/DEB_W");
    end

    logic [CH_NUM-1:0] r_dly1;
    logic [CH_NUM-1:0] w_lvl_cur;    // level used for edge detection
    logic [CH_NUM-1:0] w_lvl_prev;   // same level one cycle earlier

`ifdef EDGE_ARB_DEBOUNCE_EN
    logic [CH_NUM-1:0] r_deb;
    logic [CH_NUM-1:0] r_deb_d;
    logic [DEB_W-1:0]  r_deb_cnt [CH_NUM];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dly1  <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < CH_NUM; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_dly1  <= ctrl_signal;
            r_deb_d <= r_deb;
            for (int i = 0; i < CH_NUM; i++) begin
                if (r_dly1[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                    // The increment on this edge would reach DEB_CYC: accept
                    // the new level, so a pulse of exactly DEB_CYC cycles passes.
                    r_deb[i]     <= r_dly1[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign w_lvl_cur  = r_deb;
    assign w_lvl_prev = r_deb_d;
`else
    logic [CH_NUM-1:0] r_dly2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dly1 <= '0;
            r_dly2 <= '0;
        end else begin
            r_dly1 <= ctrl_signal;
            r_dly2 <= r_dly1;
        end
    end

    assign w_lvl_cur  = r_dly1;
    assign w_lvl_prev = r_dly2;
`endif

    // ------------------------------------------------------------------ edges
    logic [CH_NUM-1:0] w_rise;
    logic [CH_NUM-1:0] w_fall;
    logic [CH_NUM-1:0] w_edge;

    always_comb begin
        w_rise = '0;
        w_fall = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_rise[i] = w_lvl_cur[i] & ~w_lvl_prev[i] & edge_mode[2*i];
            w_fall[i] = ~w_lvl_cur[i] & w_lvl_prev[i] & edge_mode[2*i+1];
        end
    end

    assign w_edge = w_rise | w_fall;

    // ---------------------------------------------------------------- arbiter
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_NUM-1:0] r_pend;
    logic [CH_NUM-1:0] r_type;       // 1 = pending event is a rising edge
    logic [CH_NUM-1:0] r_ovf;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_evt_valid;
    logic [IDX_W-1:0]  r_evt_ch;
    logic              r_evt_rise;

    logic [IDX_W-1:0]  w_ch_inc;
    logic [IDX_W-1:0]  w_start;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [CH_NUM-1:0] w_grant;
    logic              w_load;
    logic              w_hs;

    assign w_ch_inc = (r_evt_ch == IDX_W'(CH_NUM - 1)) ? '0 : r_evt_ch + IDX_W'(1);
    assign w_hs     = (r_state == S_PRESENT) && evt_ready;
    assign w_load   = (|r_pend) && ((r_state == S_IDLE) || evt_ready);
    // A back-to-back grant searches from the channel after the one being
    // accepted, i.e. from the value rr_ptr takes on this same edge.
    assign w_start  = (r_state == S_IDLE) ? r_rr_ptr : w_ch_inc;

    always_comb begin
        int         v_j;
        logic [IDX_W-1:0] v_idx;
        logic       v_hit;
        v_j       = 0;
        v_idx     = '0;
        v_hit     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            v_j   = (int'(w_start) + k) % CH_NUM;
            v_idx = IDX_W'(v_j);
            if (!v_hit && r_pend[v_idx]) begin
                v_hit     = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_load) w_grant[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (|r_pend) w_state_nxt = S_PRESENT;
            S_PRESENT: if (evt_ready && !(|r_pend)) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pend      <= '0;
            r_type      <= '0;
            r_ovf       <= '0;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_rise  <= 1'b0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                // A new edge overrides the grant-clear; the stored type is only
                // replaced when the slot is free or being emptied this cycle.
                if (w_edge[i]) begin
                    r_pend[i] <= 1'b1;
                    if (!r_pend[i] || w_grant[i]) r_type[i] <= w_rise[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            r_ovf <= w_edge & r_pend & ~w_grant;

            if (w_hs) r_rr_ptr <= w_ch_inc;

            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_ch    <= w_gnt_idx;
                r_evt_rise  <= r_type[w_gnt_idx];
            end else if (w_hs) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign evt_rise  = r_evt_rise;
    assign pend_mask = r_pend;
    assign ovf_pulse = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_evt_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_evt_arb
// Description : Self-checking bench for edge_evt_arb. Expected events are
//               pushed to a scoreboard queue when stimulus is driven and are
//               popped by a monitor at every valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_evt_arb;

    localparam int CH_NUM  = 4;
    localparam int IDX_W   = 2;
    localparam int DEB_CYC = 15;
    localparam int DEB_W   = 4;
`ifdef EDGE_ARB_DEBOUNCE_EN
    localparam int c_LAT = 2 + DEB_CYC;
`else
    localparam int c_LAT = 2;
`endif

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [CH_NUM-1:0]   ctrl_signal = '0;
    logic [2*CH_NUM-1:0] edge_mode = '0;
    logic                evt_valid;
    logic                evt_ready = 1'b0;
    logic [IDX_W-1:0]    evt_ch;
    logic                evt_rise;
    logic [CH_NUM-1:0]   pend_mask;
    logic [CH_NUM-1:0]   ovf_pulse;

    edge_evt_arb #(
        .CH_NUM (CH_NUM),
        .IDX_W  (IDX_W),
        .DEB_CYC(DEB_CYC),
        .DEB_W  (DEB_W)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ctrl_signal(ctrl_signal),
        .edge_mode  (edge_mode),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ch     (evt_ch),
        .evt_rise   (evt_rise),
        .pend_mask  (pend_mask),
        .ovf_pulse  (ovf_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } evt_t;

    typedef struct {
        logic [3:0] ctrl;
        logic [7:0] mode;
        int         n;
        logic [7:0] chs;     // expected channel k at [2k+1:2k]
        logic [3:0] rises;   // expected rise flag k at bit k
    } vec_t;

    evt_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   run = 0;
    int   hs_last_cyc = -10;
    int   ovf_cnt [CH_NUM] = '{default: 0};
    evt_t m_e;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: overflow pulses and handshake scoreboard.
    always @(negedge sys_clk) begin
        for (int i = 0; i < CH_NUM; i++) if (ovf_pulse[i]) ovf_cnt[i]++;
        if (sys_rst_n && evt_valid && evt_ready) begin
            hs_cnt++;
            if (hs_last_cyc == cyc - 1) run++;
            else run = 1;
            hs_last_cyc = cyc;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_evt: got ch=%0d rise=%0d, expected no event", evt_ch, evt_rise);
            end else begin
                m_e = exp_q.pop_front();
                if ({evt_ch, evt_rise} !== {m_e.ch, m_e.rise}) begin
                    n_fail++;
                    $display("FAIL evt_order: got ch=%0d rise=%0d, expected ch=%0d rise=%0d",
                             evt_ch, evt_rise, m_e.ch, m_e.rise);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic push(input int ch, input logic rise);
        evt_t e;
        e.ch   = 2'(ch);
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        repeat (c_LAT + 8) tick();
        chk({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t tbl[10];

    initial begin
        int base_hs;
        int base_ovf [CH_NUM];
        int first_k;

        tbl[0] = '{4'b1111, 8'hFF, 4, 8'hE4, 4'b1111};
        tbl[1] = '{4'b0000, 8'hFF, 4, 8'hE4, 4'b0000};
        tbl[2] = '{4'b0100, 8'h55, 1, 8'h02, 4'b0001};
        tbl[3] = '{4'b0000, 8'h55, 0, 8'h00, 4'b0000};
        tbl[4] = '{4'b1010, 8'hAA, 0, 8'h00, 4'b0000};
        tbl[5] = '{4'b0000, 8'hAA, 2, 8'h07, 4'b0000};
        tbl[6] = '{4'b0011, 8'h04, 1, 8'h01, 4'b0001};
        tbl[7] = '{4'b0000, 8'hFF, 2, 8'h04, 4'b0000};
        tbl[8] = '{4'b1001, 8'hFF, 2, 8'h03, 4'b0011};
        tbl[9] = '{4'b0000, 8'hFF, 2, 8'h03, 4'b0000};

        // ---- reset state
        edge_mode = 8'hFF;
        repeat (3) tick();
        chk("rst_outs", 32'({evt_valid, evt_ch, evt_rise, pend_mask, ovf_pulse}), 0);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("idle_valid", 32'(evt_valid), 0);
            chk("idle_pend", 32'(pend_mask), 0);
        end

        // ---- table-driven vectors, consumer always ready
        evt_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            base_hs = hs_cnt;
            for (int k = 0; k < tbl[r].n; k++) push(int'(tbl[r].chs[2*k +: 2]), tbl[r].rises[k]);
            ctrl_signal = tbl[r].ctrl;
            edge_mode   = tbl[r].mode;
            wait_drain($sformatf("row%0d", r));
            chk($sformatf("row%0d_count", r), 32'(hs_cnt - base_hs), 32'(tbl[r].n));
            if (tbl[r].n > 0) chk($sformatf("row%0d_b2b", r), 32'(run), 32'(tbl[r].n));
        end

        // ---- ch2 single rise: latency and single-cycle valid
        edge_mode   = 8'h55;
        push(2, 1'b1);
        ctrl_signal = 4'b0100;
        for (int k = 0; k <= c_LAT + 3; k++) begin
            tick();
            chk($sformatf("lat_ch2_k%0d", k), 32'(evt_valid), 32'(k == c_LAT));
        end
        ctrl_signal = 4'b0000;
        wait_drain("ch2_fall");

`ifndef EDGE_ARB_DEBOUNCE_EN
        // ---- overflow while port is busy with ch0
        for (int i = 0; i < CH_NUM; i++) base_ovf[i] = ovf_cnt[i];
        edge_mode   = 8'hFF;
        evt_ready   = 1'b0;
        ctrl_signal = 4'b0001;
        repeat (4) tick();
        chk("hold_valid", 32'(evt_valid), 1);
        chk("hold_ch", 32'(evt_ch), 0);
        ctrl_signal = 4'b0011;
        repeat (4) tick();
        ctrl_signal = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stable_ch", 32'({evt_valid, evt_ch, evt_rise}), 32'({1'b1, 2'd0, 1'b1}));
        end
        chk("ovf_pend", 32'(pend_mask), 32'(4'b0010));
        chk("ovf_ch1", 32'(ovf_cnt[1] - base_ovf[1]), 1);
        chk("ovf_other", 32'((ovf_cnt[0] - base_ovf[0]) + (ovf_cnt[2] - base_ovf[2]) + (ovf_cnt[3] - base_ovf[3])), 0);
        push(0, 1'b1);
        push(1, 1'b1);
        evt_ready = 1'b1;
        wait_drain("ovf");
        chk("ovf_pend_clr", 32'(pend_mask), 0);
        edge_mode   = 8'h00;
        ctrl_signal = 4'b0000;
        repeat (5) tick();

        // ---- ch3 toggles on its own grant cycle
        for (int i = 0; i < CH_NUM; i++) base_ovf[i] = ovf_cnt[i];
        edge_mode = 8'hFF;
        push(3, 1'b1);
        push(3, 1'b0);
        ctrl_signal = 4'b1000;
        tick();
        ctrl_signal = 4'b0000;
        wait_drain("grant_toggle");
        chk("grant_toggle_b2b", 32'(run), 2);
        chk("grant_toggle_ovf", 32'(ovf_cnt[3] - base_ovf[3]), 0);
`else
        // ---- debounce: short glitch filtered, long level delayed
        edge_mode = 8'h01;
        base_hs   = hs_cnt;
        ctrl_signal = 4'b0001;
        repeat (10) tick();
        ctrl_signal = 4'b0000;
        repeat (40) tick();
        chk("deb_glitch", 32'(hs_cnt - base_hs), 0);
        push(0, 1'b1);
        first_k = -1;
        ctrl_signal = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 19) ctrl_signal = 4'b0000;
            if (evt_valid && first_k < 0) first_k = k;
        end
        chk("deb_latency", 32'(first_k), 32'(c_LAT));
        wait_drain("deb_level");
`endif

        // ---- reset asserted mid-handshake
        base_hs     = hs_cnt;
        evt_ready   = 1'b0;
        edge_mode   = 8'hFF;
        ctrl_signal = 4'b0101;
        repeat (c_LAT + 4) tick();
        chk("pre_rst_valid", 32'(evt_valid), 1);
        chk("pre_rst_pend", 32'($countones(pend_mask)), 1);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({evt_valid, evt_ch, evt_rise, pend_mask}), 0);
        ctrl_signal = 4'b0000;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        evt_ready = 1'b1;
        repeat (c_LAT + 20) tick();
        chk("post_rst_valid", 32'(evt_valid), 0);
        chk("post_rst_hs", 32'(hs_cnt - base_hs), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
